// File: rtl/time_disp_pkg.sv
// Shared constants, digit positions and the divider-free BCD split
// used by the time display scanner.
package time_disp_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Encoder input codes beyond the decimal digits.
  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  // Scan position; value equals the o_digit_sel bit it drives.
  typedef enum logic [2:0] {
    DIG_SEC_ONES  = 3'd0,
    DIG_SEC_TENS  = 3'd1,
    DIG_MIN_ONES  = 3'd2,
    DIG_MIN_TENS  = 3'd3,
    DIG_HOUR_ONES = 3'd4,
    DIG_HOUR_TENS = 3'd5
  } digit_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_pair_t;

  // Splits 0..59 into tens/ones with threshold compares only; values
  // above max_v turn both digits into dashes.
  function automatic bcd_pair_t split_bcd(input int unsigned v, input int unsigned max_v);
    bcd_pair_t r;
    if (v > max_v)      r = '{CODE_DASH, CODE_DASH};
    else if (v >= 50)   r = '{4'd5, 4'(v - 50)};
    else if (v >= 40)   r = '{4'd4, 4'(v - 40)};
    else if (v >= 30)   r = '{4'd3, 4'(v - 30)};
    else if (v >= 20)   r = '{4'd2, 4'(v - 20)};
    else if (v >= 10)   r = '{4'd1, 4'(v - 10)};
    else                r = '{4'd0, 4'(v)};
    return r;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational digit code to active-low 7-segment pattern.
// Codes 0..9 are decimal digits, 10 is a dash, anything else blanks.
module seg7_encoder
  import time_disp_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Code lookup; unlisted codes fall through to blank.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    o_seg = SEG_BLANK;
    case (i_code)
      4'd0:      o_seg = SEG_0;
      4'd1:      o_seg = SEG_1;
      4'd2:      o_seg = SEG_2;
      4'd3:      o_seg = SEG_3;
      4'd4:      o_seg = SEG_4;
      4'd5:      o_seg = SEG_5;
      4'd6:      o_seg = SEG_6;
      4'd7:      o_seg = SEG_7;
      4'd8:      o_seg = SEG_8;
      4'd9:      o_seg = SEG_9;
      CODE_DASH: o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_display_scanner.sv
// Six-digit multiplexed HH:MM:SS display driver for a common-anode
// 7-segment module. Snapshots the time once per frame, splits each field
// into BCD digits and scans one digit per P_SCAN_DIV clocks.
// Optional build macro COLON_BLINK_EN: colon dots blink with seconds parity.
module time_display_scanner
  import time_disp_pkg::*;
#(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_SCAN_BIT = 17,
  parameter int P_SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_minute,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  output logic [6:0]            o_seg,
  output logic                  o_dp,
  output logic [5:0]            o_digit_sel
);

  logic [P_SCAN_BIT-1:0] r_scan_cnt;
  digit_e                r_idx;
  digit_e                w_idx_next;
  logic                  r_en_d;
  logic [P_SEC_BIT-1:0]  r_snap_sec;
  logic [P_MIN_BIT-1:0]  r_snap_min;
  logic [P_HOUR_BIT-1:0] r_snap_hour;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [5:0]            r_digit_sel;

  logic                  w_slot_last;
  logic                  w_wrap;
  logic                  w_load_rise;
  logic                  w_load_frame;
  logic [P_SEC_BIT-1:0]  w_sec;
  logic [P_MIN_BIT-1:0]  w_min;
  logic [P_HOUR_BIT-1:0] w_hour;
  bcd_pair_t             w_sec_bcd;
  bcd_pair_t             w_min_bcd;
  bcd_pair_t             w_hour_bcd;
  logic [3:0]            w_code;
  logic                  w_dp_on;
  logic [6:0]            w_seg;
  logic [5:0]            w_sel_onehot;

  assign w_slot_last  = (r_scan_cnt == P_SCAN_BIT'(P_SCAN_DIV - 1));
  assign w_wrap       = i_en & w_slot_last;
  assign w_load_rise  = i_en & ~r_en_d;
  assign w_load_frame = w_wrap & (r_idx == DIG_HOUR_TENS);

  // On the enable-rise cycle the output stage must already see the fresh
  // inputs; on a frame wrap it is still finishing digit 5 of the old frame.
  assign w_sec  = w_load_rise ? i_sec    : r_snap_sec;
  assign w_min  = w_load_rise ? i_minute : r_snap_min;
  assign w_hour = w_load_rise ? i_hour   : r_snap_hour;

  assign w_sec_bcd  = split_bcd(32'(w_sec),  59);
  assign w_min_bcd  = split_bcd(32'(w_min),  59);
  assign w_hour_bcd = split_bcd(32'(w_hour), 23);

  assign w_sel_onehot = 6'(1) << r_idx;

  // Next scan position: advance on prescaler wrap, 5 returns to 0.
  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) begin
      if (r_idx == DIG_HOUR_TENS) w_idx_next = DIG_SEC_ONES;
      else                        w_idx_next = digit_e'(r_idx + 3'd1);
    end
  end

  // Select the digit code and colon request for the current position.
  always_comb begin
    w_code  = CODE_BLANK;
    w_dp_on = 1'b0;
    case (r_idx)
      DIG_SEC_ONES:  w_code = w_sec_bcd.ones;
      DIG_SEC_TENS:  w_code = w_sec_bcd.tens;
      DIG_MIN_ONES:  w_code = w_min_bcd.ones;
      DIG_MIN_TENS:  w_code = w_min_bcd.tens;
      DIG_HOUR_ONES: w_code = w_hour_bcd.ones;
      DIG_HOUR_TENS: w_code = w_hour_bcd.tens;
      default:       w_code = CODE_BLANK;
    endcase
    if (r_idx == DIG_MIN_ONES || r_idx == DIG_HOUR_ONES) begin
`ifdef COLON_BLINK_EN
      w_dp_on = (32'(w_sec) <= 59) && !w_sec[0];
`else
      w_dp_on = 1'b1;
`endif
    end
  end

  seg7_encoder u_seg7_encoder (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // Prescaler, scan index and enable-edge tracker.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_scan_cnt <= '0;
      r_idx      <= DIG_SEC_ONES;
      r_en_d     <= 1'b0;
    end else begin
      r_en_d <= i_en;
      r_idx  <= w_idx_next;
      if (i_en) r_scan_cnt <= w_slot_last ? '0 : r_scan_cnt + P_SCAN_BIT'(1);
    end
  end

  // Frame snapshot: all three fields load together for a tear-free frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_snap_sec  <= '0;
      r_snap_min  <= '0;
      r_snap_hour <= '0;
    end else if (w_load_rise || w_load_frame) begin
      r_snap_sec  <= i_sec;
      r_snap_min  <= i_minute;
      r_snap_hour <= i_hour;
    end
  end

  // Registered pin drivers; digit enables drop on each slot's last cycle.
  always_ff @(posedge clk) begin
    if (!reset || !i_en) begin
      r_seg       <= SEG_BLANK;
      r_dp        <= 1'b1;
      r_digit_sel <= 6'h3F;
    end else begin
      r_seg       <= w_seg;
      r_dp        <= ~w_dp_on;
      r_digit_sel <= w_slot_last ? 6'h3F : ~w_sel_onehot;
    end
  end

  assign o_seg       = r_seg;
  assign o_dp        = r_dp;
  assign o_digit_sel = r_digit_sel;

endmodule
